vc_read_arbiter: RTL

Read-side arbiter for the two virtual-channel FIFOs (VC0, VC1) of the transmission-layer datapath. It watches the FIFO status flags and issues `pop_VC0_fifo`/`pop_VC1_fifo`. It captures the popped word and pushes it into one of two destination FIFOs (D0, D1), selected by the word's destination bit. It applies strict VC0 priority with a bounded anti-starvation rule and stalls on downstream back-pressure.

---
 rtl/vc_read_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vc_read_arbiter.sv
// vc_read_arbiter
// Read-side arbiter for the two virtual-channel FIFOs (VC0, VC1). It watches
// the VC FIFO status flags, issues pop strobes, captures the word returned
// one cycle later and forwards it to destination FIFO D0 or D1 according to
// the word's destination bit (data_width-2). VC0 has strict priority, except
// that VC1 is forced once after starve_limit consecutive VC0 grants that
// were made while VC1 was waiting. Any almost_full on D0/D1 stalls new pops.
//
// Ports:
//   clk                    in   rising-edge clock
//   reset                  in   asynchronous reset, active low (0 = in reset)
//   empty_fifo_VCx         in   VCx FIFO empty
//   almost_empty_fifo_VCx  in   VCx FIFO holds at most one word
//   data_out_VCx           in   VCx read data, valid the cycle after the pop
//   almost_full_D0/D1      in   destination FIFO back-pressure
//   pop_VC0/VC1_fifo       out  registered pop strobes, mutually exclusive
//   data_out               out  registered word toward D0/D1, holds when idle
//   push_D0/D1             out  registered push strobes, mutually exclusive
//   busy                   out  a popped word is still in the pipeline

module vc_read_arbiter #(
  parameter int data_width   = 6,
  parameter int starve_limit = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_fifo_VC0,
  input  logic                  almost_empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic                  almost_empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic [data_width-1:0] data_out,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic                  busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(starve_limit);

  // r_armed keeps the first edge after reset release from popping, so the
  // earliest pop lands on the second rising edge.
  logic                  r_armed;
  logic                  r_validB;
  logic                  r_srcB;
  logic [CNT_W-1:0]      r_starveCnt;

  logic                  w_noBackpressure;
  logic                  w_eligVC0;
  logic                  w_eligVC1;
  logic                  w_forceVC1;
  logic                  w_grantVC0;
  logic                  w_grantVC1;
  logic [CNT_W-1:0]      w_starveNext;
  logic [data_width-1:0] w_wordB;
  logic                  w_destB;

  // Eligibility and grant. The destination of the next word is unknown
  // before it is popped, so either almost_full blocks both VCs. A VC that is
  // being popped right now while flagged almost-empty is giving up its last
  // word; its empty flag has not caught up yet, so it is skipped next cycle.
  always_comb begin
    w_noBackpressure = ~almost_full_D0 & ~almost_full_D1;
    w_eligVC0  = r_armed & w_noBackpressure & ~empty_fifo_VC0 &
                 ~(pop_VC0_fifo & almost_empty_fifo_VC0);
    w_eligVC1  = r_armed & w_noBackpressure & ~empty_fifo_VC1 &
                 ~(pop_VC1_fifo & almost_empty_fifo_VC1);
    w_forceVC1 = (r_starveCnt == LIMIT);
    w_grantVC0 = w_eligVC0 & ~(w_eligVC1 & w_forceVC1);
    w_grantVC1 = w_eligVC1 & ~(w_eligVC0 & ~w_forceVC1);
  end

  // Starvation counter: counts VC0 wins over a waiting VC1, saturating at
  // the limit; any VC1 grant or VC1 going ineligible restarts it.
  always_comb begin
    w_starveNext = r_starveCnt;
    if (w_grantVC1 || !w_eligVC1) begin
      w_starveNext = '0;
    end else if (w_grantVC0 && (r_starveCnt != LIMIT)) begin
      w_starveNext = r_starveCnt + 1'b1;
    end
  end

  // Stage B: the VC FIFO presents the popped word this cycle.
  always_comb begin
    w_wordB = r_srcB ? data_out_VC1 : data_out_VC0;
    w_destB = w_wordB[data_width-2];
  end

  // Stage A: pop strobes, arming flag and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      pop_VC0_fifo <= 1'b0;
      pop_VC1_fifo <= 1'b0;
      r_starveCnt  <= '0;
    end else begin
      r_armed      <= 1'b1;
      pop_VC0_fifo <= w_grantVC0;
      pop_VC1_fifo <= w_grantVC1;
      r_starveCnt  <= w_starveNext;
    end
  end

  // Stages B and C: remember which VC was popped, then register the word
  // and the push toward its destination. Back-pressure does not reach here,
  // so words already popped always complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_validB <= 1'b0;
      r_srcB   <= 1'b0;
      push_D0  <= 1'b0;
      push_D1  <= 1'b0;
      data_out <= '0;
    end else begin
      r_validB <= pop_VC0_fifo | pop_VC1_fifo;
      r_srcB   <= pop_VC1_fifo;
      push_D0  <= r_validB & ~w_destB;
      push_D1  <= r_validB & w_destB;
      if (r_validB) begin
        data_out <= w_wordB;
      end
    end
  end

  assign busy = pop_VC0_fifo | pop_VC1_fifo | r_validB;

endmodule
